// File: rtl/arb8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb8_pkg;

    localparam int CNTW = 8;
    localparam int NREQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_TURN
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request scanning from ptr
// upward, wrapping 7 -> 0. Reusable by any 8-way arbiter.
module rr_pick8
    import arb8_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [2:0]      win,
    output logic            valid
);

    logic [NREQ-1:0] rot;
    logic [2:0]      off;

    // Rotate so bit 0 is the requester at ptr, then take the lowest set bit
    // and translate the offset back to an absolute index.
    always_comb begin
        rot   = NREQ'({req, req} >> ptr);
        off   = 3'd0;
        valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = 3'(i);
                valid = 1'b1;
            end
        end
        win = 3'(ptr + off);
    end

endmodule

// File: rtl/arb8.sv
// Round-robin arbiter and mux sequencer for an 8-way shared resource.
// Grants one owner at a time, limits bursts once others wait, and inserts
// turnaround cycles so the mux select never moves under a live grant.
module arb8
    import arb8_pkg::*;
#(
    parameter int MAXBURST = 8,
    parameter int TURN     = 1
)
(
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      sel,
    output logic            busy
);

    localparam logic [CNTW-1:0] MAXB  = CNTW'(MAXBURST);
    localparam logic [1:0]      TURNV = 2'(TURN);

    state_t          state, state_n;
    logic [2:0]      ptr, ptr_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [1:0]      tcnt, tcnt_n;
    logic [NREQ-1:0] gnt_n;
    logic [2:0]      sel_n;
    logic [2:0]      win;
    logic            win_valid;
    logic            owner_req;
    logic            others_req;
    logic            end_grant;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .win   (win),
        .valid (win_valid)
    );

    // Owner is whoever sel points at; a grant ends on release or when the
    // burst limit is hit while someone else is waiting.
    always_comb begin
        owner_req  = req[sel];
        others_req = |(req & ~gnt);
        end_grant  = !owner_req || ((cnt >= MAXB) && others_req);
    end

    // Next-state logic for FSM, pointer, counters and registered outputs.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        tcnt_n  = tcnt;
        gnt_n   = gnt;
        sel_n   = sel;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    gnt_n   = NREQ'(1) << win;
                    sel_n   = win;
                    cnt_n   = CNTW'(1);
                    state_n = ST_OWN;
                end
            end
            ST_OWN: begin
                if (end_grant) begin
                    gnt_n = '0;
                    ptr_n = 3'(sel + 3'd1);
                    if (TURNV != 2'd0) begin
                        state_n = ST_TURN;
                        tcnt_n  = TURNV;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (cnt < MAXB) begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
            ST_TURN: begin
                gnt_n = '0;
                if (tcnt <= 2'd1) begin
                    state_n = ST_IDLE;
                    tcnt_n  = 2'd0;
                end else begin
                    tcnt_n = tcnt - 2'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
            ptr   <= 3'd0;
            cnt   <= '0;
            tcnt  <= 2'd0;
            gnt   <= '0;
            sel   <= 3'd0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            tcnt  <= tcnt_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_arb8.sv
// Directed scoreboard bench for arb8: main instance (MAXBURST=8, TURN=1)
// and a second instance (MAXBURST=3, TURN=0) for the no-turnaround case.
module tb_arb8;

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] req, req0;
    logic [7:0] gnt, gnt0;
    logic [2:0] sel, sel0;
    logic       busy, busy0;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int         unit;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        string      tag;
    } exp_t;

    exp_t sb[$];

    arb8 #(.MAXBURST(8), .TURN(1)) u_dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy)
    );

    arb8 #(.MAXBURST(3), .TURN(0)) u_dut0 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (req0),
        .gnt     (gnt0),
        .sel     (sel0),
        .busy    (busy0)
    );

    // Free-running clock, 10 time units per cycle.
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Pop the oldest expectation and compare it with the chosen instance.
    task automatic check_output();
        exp_t       e;
        logic [7:0] og;
        logic [2:0] os;
        logic       ob;
        tests_run++;
        assert (sb.size() != 0) else begin
            tests_failed++;
            $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
        end
        if (sb.size() != 0) begin
            e  = sb.pop_front();
            og = (e.unit == 0) ? gnt  : gnt0;
            os = (e.unit == 0) ? sel  : sel0;
            ob = (e.unit == 0) ? busy : busy0;
            tests_run++;
            assert (og === e.gnt) else begin
                tests_failed++;
                $error("[TB] FAIL %s gnt: observed %h expected %h", e.tag, og, e.gnt);
            end
            tests_run++;
            assert (os === e.sel) else begin
                tests_failed++;
                $error("[TB] FAIL %s sel: observed %0d expected %0d", e.tag, os, e.sel);
            end
            tests_run++;
            assert (ob === e.busy) else begin
                tests_failed++;
                $error("[TB] FAIL %s busy: observed %b expected %b", e.tag, ob, e.busy);
            end
        end
    endtask

    // Drive one cycle of inputs, record what must appear after the edge,
    // then sample 1 time unit past the edge and check.
    task automatic apply_stimulus(input logic rst, input logic [7:0] r_main,
                                  input logic [7:0] r_alt, input int unit,
                                  input logic [7:0] eg, input logic [2:0] es,
                                  input logic eb, input string tag);
        exp_t e;
        sys_rst = rst;
        req     = r_main;
        req0    = r_alt;
        e.unit  = unit;
        e.gnt   = eg;
        e.sel   = es;
        e.busy  = eb;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge sys_clk);
        #1;
        check_output();
    endtask

    // Linear sequence of directed steps.
    initial begin
        sys_rst = 1'b1;
        req     = 8'h00;
        req0    = 8'h00;

        // Reset and idle, then first grant latency.
        apply_stimulus(1, 8'h00, 8'h00, 0, 8'h00, 3'd0, 0, "reset0");
        apply_stimulus(1, 8'h00, 8'h00, 0, 8'h00, 3'd0, 0, "reset1");
        apply_stimulus(0, 8'h00, 8'h00, 1, 8'h00, 3'd0, 0, "reset_alt");
        apply_stimulus(0, 8'h00, 8'h00, 0, 8'h00, 3'd0, 0, "idle");
        apply_stimulus(0, 8'h10, 8'h00, 0, 8'h10, 3'd4, 1, "first_gnt");
        apply_stimulus(0, 8'h00, 8'h00, 0, 8'h00, 3'd4, 1, "first_rel");
        apply_stimulus(0, 8'h00, 8'h00, 0, 8'h00, 3'd4, 0, "first_idle");

        // Full rotation with all requesters: 8 owned cycles, 2-cycle gap.
        apply_stimulus(1, 8'h00, 8'h00, 0, 8'h00, 3'd0, 0, "rot_reset");
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 8; c++) begin
                apply_stimulus(0, 8'hFF, 8'h00, 0, 8'(1 << k), 3'(k), 1,
                               $sformatf("rot_own k%0d c%0d", k, c));
            end
            apply_stimulus(0, 8'hFF, 8'h00, 0, 8'h00, 3'(k), 1, $sformatf("rot_turn k%0d", k));
            apply_stimulus(0, 8'hFF, 8'h00, 0, 8'h00, 3'(k), 0, $sformatf("rot_idle k%0d", k));
        end
        apply_stimulus(0, 8'hFF, 8'h00, 0, 8'h01, 3'd0, 1, "rot_wrap");

        // Owner 7 releases with 1 and 3 waiting: pointer wraps to 0, picks 1.
        apply_stimulus(1, 8'h00, 8'h00, 0, 8'h00, 3'd0, 0, "wrap_reset");
        apply_stimulus(0, 8'h80, 8'h00, 0, 8'h80, 3'd7, 1, "wrap_own7");
        apply_stimulus(0, 8'h8A, 8'h00, 0, 8'h80, 3'd7, 1, "wrap_hold7");
        apply_stimulus(0, 8'h0A, 8'h00, 0, 8'h00, 3'd7, 1, "wrap_rel");
        apply_stimulus(0, 8'h0A, 8'h00, 0, 8'h00, 3'd7, 0, "wrap_idle");
        apply_stimulus(0, 8'h0A, 8'h00, 0, 8'h02, 3'd1, 1, "wrap_gnt1");
        apply_stimulus(0, 8'h00, 8'h00, 0, 8'h00, 3'd1, 1, "wrap_rel1");
        apply_stimulus(0, 8'h00, 8'h00, 0, 8'h00, 3'd1, 0, "wrap_idle1");

        // Lone owner is never preempted; a new requester forces a handover.
        for (int c = 0; c < 40; c++) begin
            apply_stimulus(0, 8'h04, 8'h00, 0, 8'h04, 3'd2, 1, $sformatf("lone c%0d", c));
        end
        apply_stimulus(0, 8'h24, 8'h00, 0, 8'h00, 3'd2, 1, "lone_preempt");
        apply_stimulus(0, 8'h24, 8'h00, 0, 8'h00, 3'd2, 0, "lone_idle");
        apply_stimulus(0, 8'h24, 8'h00, 0, 8'h20, 3'd5, 1, "lone_gnt5");
        apply_stimulus(0, 8'h00, 8'h00, 0, 8'h00, 3'd5, 1, "lone_rel5");
        apply_stimulus(0, 8'h00, 8'h00, 0, 8'h00, 3'd5, 0, "lone_idle5");

        // Reset in the middle of a grant to requester 6.
        apply_stimulus(0, 8'h40, 8'h00, 0, 8'h40, 3'd6, 1, "mid_own6");
        apply_stimulus(0, 8'h40, 8'h00, 0, 8'h40, 3'd6, 1, "mid_hold6");
        apply_stimulus(1, 8'hC0, 8'h00, 0, 8'h00, 3'd0, 0, "mid_reset");
        apply_stimulus(0, 8'hC0, 8'h00, 0, 8'h40, 3'd6, 1, "mid_regnt");

        // No-turnaround instance: two requesters alternate, one dead cycle.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                apply_stimulus(0, 8'h00, 8'h03, 1, 8'h01, 3'd0, 1, $sformatf("t0_own0 r%0d c%0d", r, c));
            end
            apply_stimulus(0, 8'h00, 8'h03, 1, 8'h00, 3'd0, 0, $sformatf("t0_gap0 r%0d", r));
            for (int c = 0; c < 3; c++) begin
                apply_stimulus(0, 8'h00, 8'h03, 1, 8'h02, 3'd1, 1, $sformatf("t0_own1 r%0d c%0d", r, c));
            end
            apply_stimulus(0, 8'h00, 8'h03, 1, 8'h00, 3'd1, 0, $sformatf("t0_gap1 r%0d", r));
        end
        apply_stimulus(0, 8'h00, 8'h03, 1, 8'h01, 3'd0, 1, "t0_again0");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/arb8.md
# arb8

Round-robin arbiter and sequencer for an 8-way shared resource whose data path is an 8:1 select multiplexer (select inputs s2..s0). Up to eight requesters compete for the resource. The block grants ownership to one requester at a time and drives the multiplexer select lines. It also enforces a burst limit and inserts turnaround cycles between owners so the selected source never changes while a grant is live.

## Interface
Parameters:
- MAXBURST, default 8: maximum owned cycles once another requester is waiting; valid range 1..255.
- TURN, default 1: dead cycles inserted after a grant ends, before re-arbitration; valid range 0..3.

Ports:
- sys_clk  in  1  single clock; all state changes on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- req  in  8  request per requester; held high while the requester wants the resource.
- gnt  out  8  one-hot grant, registered; all-zero when no owner.
- sel  out  3  multiplexer select {s2,s1,s0}, registered; equals index of current or last owner.
- busy  out  1  high in OWN or TURN state.

## Operation
- States: IDLE, OWN, TURN. Reset state is IDLE.
- Reset values: gnt=0, sel=0, busy=0. The round-robin pointer ptr=0, the burst counter cnt=0, and the turnaround counter=0.
- IDLE:
  - If req is zero, stay in IDLE.
  - Otherwise pick the winner w: the first set bit of req scanning ptr, ptr+1 … wrapping 7→0.
  - Next edge: gnt=1<<w, sel=w, cnt=1, state=OWN.
- OWN, with owner o:
  - Release: if req[o]=0, end the grant.
  - Preemption: if cnt>=MAXBURST and (req & ~(1<<o))≠0, end the grant.
  - Otherwise cnt increments, saturating at MAXBURST.
  - If only the owner requests, it is never preempted.
- Ending a grant (next edge): gnt=0, ptr=(o+1) mod 8. If TURN>0, state=TURN with turnaround counter=TURN; if TURN=0, state=IDLE.
- TURN: gnt=0. Decrement the turnaround counter; when it reaches 1, go to IDLE at the next edge.
- sel changes only on the edge where a new gnt is issued. It holds its value through OWN, TURN and IDLE.
- gnt is never multi-hot. A gnt bit is never set while sel mismatches it.
- Requests that rise and fall while not granted are ignored; req is not latched.
- Reset asserted mid-grant: gnt=0, ptr=0, state=IDLE at that edge; sel returns to 0.

## Timing
- Grant latency: req rises, and is sampled at edge n in IDLE, giving gnt at edge n+1 (1 cycle).
- Release: req[o] is sampled low at edge n, gnt drops at edge n+1. The next grant appears at edge n+2+TURN, or n+2 when TURN=0 (one idle cycle minimum).
- Preemption: the owner holds gnt for exactly MAXBURST cycles, then gnt drops on the following edge.
- Steady back-to-back contention gives a period of MAXBURST+1+TURN cycles per grant.
- The arbitration decision uses only req and ptr sampled at the same edge. There is no combinational req→gnt path.

## Structure
- Package arb8_pkg holds:
  - the state enum (IDLE, OWN, TURN);
  - the counter width constant CNTW=8;
  - the requester count constant NREQ=8.
- One natural sub-module, rr_pick8: a combinational picker taking req[7:0] and ptr[2:0] and producing winner index[2:0] plus a valid flag. It is reused by any other 8-way arbiter in the design.
- Top level holds the FSM, ptr, cnt, turnaround counter and the output registers.

## Test plan
- Reset/idle: sys_rst high 2 cycles, req=0 → gnt=0, sel=0, busy=0 throughout. Then req=8'h10 → gnt=8'h10, sel=4 exactly 1 cycle later.
- Rotation: TURN=1, MAXBURST=8, req=8'hFF held → grant order 0,1,2…7,0. Each gnt lasts 8 cycles with a 2-cycle gap (1 release + 1 turn).
- Release and wrap: owner 7 drops req while req[1] and req[3] are high → after the gap, gnt=8'h02, not 8'h08. ptr wraps 7→0 and scans to 1.
- Lone owner: req=8'h04 held for 40 cycles, MAXBURST=8 → gnt=8'h04 continuous, no preemption. Raising req[5] at cycle 40 → gnt drops on the next edge, and gnt=8'h20 follows.
- TURN=0: two requesters alternate → exactly 1 cycle of gnt=0 between owners. sel changes only on the edge where gnt rises.
- Reset mid-grant: sys_rst pulsed while gnt=8'h40 → gnt=0 and sel=0 at that edge. With req=8'hC0 after reset, the next grant is 8'h40 (ptr=0 scan).
